// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared PC width, pc_op/cond/fetch-state enums and branch-condition helper
package fetch_sequencer_pkg;
  localparam int PC_W = 12;
  typedef enum logic [2:0] {OP_NEXT, OP_BRANCH, OP_JMP, OP_JSR, OP_RET, OP_RETI, OP_INT} pc_op_e;
  typedef enum logic [1:0] {CND_Z, CND_NZ, CND_C, CND_NC} cond_e;
  typedef enum logic {ST_IDLE, ST_FETCH} fetch_state_e;
  function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic c);
    return cond[1] ? (c ^ cond[0]) : (z ^ cond[0]);
  endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction bus (cyc/stb/adr from master, ack from slave)
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;
  logic cyc;
  logic stb;
  logic ack;
  logic [PC_W-1:0] adr;
  modport master (output cyc, stb, adr, input ack);
  modport slave (input cyc, stb, adr, output ack);
endinterface

// File: rtl/fetch_sequencer_ret_stack.sv
// fetch_sequencer_ret_stack: LIFO return stack; push_i/pop_i/data_i in, top_o/full_o/empty_o out
module fetch_sequencer_ret_stack #(
  parameter int DEPTH = 8,
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] sp_q, sp_d, top_idx;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  assign full_o = sp_q == (AW+1)'(DEPTH);
  assign empty_o = sp_q == '0;
  assign top_idx = sp_q - (AW+1)'(1);
  assign top_o = mem_q[top_idx[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (push_i && !full_o) mem_d[sp_q[AW-1:0]] = data_i;
    sp_d = (push_i && !full_o) ? sp_q + (AW+1)'(1) : (pop_i && !empty_o) ? top_idx : sp_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      sp_q <= sp_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC + fetch FSM; clk_i/rst_ni/cen_i, pc_op/cond control, flags, irq, inst bus via fetch_sequencer_if, isr/stack status out
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(0),
  parameter logic [PC_W-1:0] INT_VECTOR   = PC_W'(1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cen_i,
  input  logic            fetch_c,
  input  logic            pc_upd_c,
  input  logic [2:0]      pc_op_c,
  input  logic [1:0]      cond_c,
  input  logic [7:0]      disp_i,
  input  logic [PC_W-1:0] addr_i,
  input  logic            ccZ_i,
  input  logic            ccC_i,
  input  logic            int_req_i,
  fetch_sequencer_if.master bus,
  output logic            int_pend_o,
  output logic            int_ack_o,
  output logic            intz_o,
  output logic            intc_o,
  output logic            in_isr_o,
  output logic            stk_ovf_o,
  output logic            stk_unf_o,
  output logic            busy_o
);
  fetch_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, int_pc_q, int_pc_d, pc_inc, br_tgt, pc_nxt, stk_top;
  logic cyc_q, cyc_d, in_isr_q, in_isr_d, intz_q, intz_d, intc_q, intc_d;
  logic int_ack_q, int_ack_d, ovf_q, ovf_d, unf_q, unf_d;
  logic upd, int_take, stk_full, stk_empty;
  assign pc_inc = pc_q + PC_W'(1);
  assign br_tgt = pc_inc + PC_W'($signed(disp_i));
  assign upd = state_q == ST_IDLE && pc_upd_c;
  assign int_pend_o = rst_ni && int_req_i && !in_isr_q;
  assign int_take = upd && pc_op_c == OP_INT && int_pend_o;
  fetch_sequencer_ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cen_i && upd && pc_op_c == OP_JSR),
    .pop_i   (cen_i && upd && pc_op_c == OP_RET),
    .data_i  (pc_inc),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );
  always_comb begin
    case (pc_op_c)
      OP_BRANCH:      pc_nxt = cond_met(cond_c, ccZ_i, ccC_i) ? br_tgt : pc_inc;
      OP_JMP, OP_JSR: pc_nxt = addr_i;
      OP_RET:         pc_nxt = stk_empty ? pc_inc : stk_top;
      OP_RETI:        pc_nxt = in_isr_q ? int_pc_q : pc_inc;
      OP_INT:         pc_nxt = int_pend_o ? INT_VECTOR : pc_inc;
      default:        pc_nxt = pc_inc;
    endcase
  end
  always_comb begin
    state_d = state_q == ST_IDLE ? (fetch_c ? ST_FETCH : ST_IDLE) : (bus.ack ? ST_IDLE : ST_FETCH);
    cyc_d = state_d == ST_FETCH;
    pc_d = upd ? pc_nxt : pc_q;
    in_isr_d = int_take || (in_isr_q && !(upd && pc_op_c == OP_RETI));
    int_pc_d = int_take ? pc_inc : int_pc_q;
    intz_d = int_take ? ccZ_i : intz_q;
    intc_d = int_take ? ccC_i : intc_q;
    int_ack_d = int_take;
    ovf_d = ovf_q || (upd && pc_op_c == OP_JSR && stk_full);
    unf_d = unf_q || (upd && pc_op_c == OP_RET && stk_empty);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cyc_q <= 1'b0;
      pc_q <= RESET_VECTOR;
      in_isr_q <= 1'b0;
      int_pc_q <= '0;
      intz_q <= 1'b0;
      intc_q <= 1'b0;
      int_ack_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (cen_i) begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      pc_q <= pc_d;
      in_isr_q <= in_isr_d;
      int_pc_q <= int_pc_d;
      intz_q <= intz_d;
      intc_q <= intc_d;
      int_ack_q <= int_ack_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign bus.cyc = cyc_q;
  assign bus.stb = cyc_q;
  assign bus.adr = pc_q;
  assign busy_o = cyc_q;
  assign int_ack_o = int_ack_q;
  assign intz_o = intz_q;
  assign intc_o = intc_q;
  assign in_isr_o = in_isr_q;
  assign stk_ovf_o = ovf_q;
  assign stk_unf_o = unf_q;
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and program-counter stage sitting directly upstream of the processing unit.
- Owns the 12-bit PC and drives the instruction bus, whose ack also strobes the instruction register.
- Computes next-PC for sequential, branch, jump, call/return and interrupt flow.
- Holds the call stack and the saved interrupt context (return PC, Z/C flags) that the processing unit restores on reti.

Parameters:
- PC_W, 12, program counter / instruction address width
- STACK_DEPTH, 8, return-stack entries (power of two)
- RESET_VECTOR, 12'h000, PC after reset
- INT_VECTOR, 12'h001, PC loaded on interrupt entry

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cen_i  in  1  clock enable; low freezes all state
- fetch_c  in  1  start instruction fetch at current PC
- pc_upd_c  in  1  apply pc_op_c this cycle
- pc_op_c  in  3  0 NEXT, 1 BRANCH, 2 JMP, 3 JSR, 4 RET, 5 RETI, 6 INT; 7 behaves as NEXT
- cond_c  in  2  branch condition: 0 Z, 1 NZ, 2 C, 3 NC
- disp_i  in  8  signed branch displacement
- addr_i  in  PC_W  absolute jump/call target
- ccZ_i, ccC_i  in  1 each  current condition flags
- int_req_i  in  1  level interrupt request
- inst_ack_i  in  1  instruction bus acknowledge
- inst_cyc_o, inst_stb_o  out  1 each  bus cycle/strobe
- inst_adr_o  out  PC_W  fetch address, equals PC
- int_pend_o  out  1  int_req_i high and not in ISR; control issues INT when set
- int_ack_o  out  1  one-cycle pulse on interrupt entry
- intz_o, intc_o  out  1 each  flags saved at interrupt entry
- in_isr_o  out  1  servicing interrupt
- stk_ovf_o, stk_unf_o  out  1 each  sticky stack error flags
- busy_o  out  1  fetch in progress

Behaviour:
- Reset (async, rst_ni low):
  - PC=RESET_VECTOR, SP=0, state IDLE.
  - All outputs 0 except inst_adr_o=RESET_VECTOR.
  - cyc/stb drop immediately, including mid-fetch.
- All updates require cen_i=1 at posedge; cyc/stb hold their value while cen_i=0.
- FSM IDLE:
  - fetch_c -> FETCH next cycle.
  - cyc=stb=busy=1 from the cycle after fetch_c.
- FSM FETCH:
  - inst_adr_o stable at PC.
  - On inst_ack_i -> IDLE; cyc/stb low the following cycle. PC unchanged by fetch.
  - fetch_c and pc_upd_c are ignored in FETCH.
  - A single-cycle ack is legal; ack in IDLE is ignored.
- pc_upd_c is sampled in IDLE only; PC is written at that edge.
- fetch_c and pc_upd_c together in IDLE: PC update applies first, and the fetch uses the new PC.
- PC arithmetic is modulo 2^PC_W (wrap-around, no flag):
  - NEXT: PC+1.
  - BRANCH: PC+1+sext(disp_i) if cond_c is true against ccZ_i/ccC_i, else PC+1.
  - JMP: addr_i.
  - JSR: push PC+1, PC=addr_i.
    - Stack full (SP==STACK_DEPTH): push dropped, stk_ovf_o set, jump still taken.
  - RET: PC=top, SP-1.
    - Stack empty: PC+1, stk_unf_o set.
  - INT (only when int_pend_o; else treated as NEXT):
    - int_pc=PC+1, intz_o=ccZ_i, intc_o=ccC_i.
    - PC=INT_VECTOR, in_isr=1, int_ack_o pulses one cycle.
  - RETI: PC=int_pc, in_isr=0. Outside ISR: PC+1, no error.
- Nested interrupts are not supported; int_req_i is masked while in_isr.
- stk_ovf_o/stk_unf_o are cleared only by reset.

Decomposition:
- Shared package: pc_op enum (NEXT..INT), cond enum, fetch state enum, PC_W constant.
- One sub-module: ret_stack (LIFO with push/pop/full/empty, DEPTH parameter).

Test Plan:
- Reset release, fetch_c, ack held 3 cycles -> cyc/stb high 3 cycles at adr 000; pc_upd NEXT -> adr 001.
- PC=010, BRANCH NZ, disp=8'hF0, ccZ=0 -> PC=001; same with ccZ=1 -> PC=011; PC=FFF NEXT -> 000.
- 9 nested JSR from PC=100 to 200 -> stk_ovf_o=1 after 9th; 8 RET pop in reverse order; 9th RET -> PC+1, stk_unf_o=1.
- int_req_i=1 at PC=050, ccZ=1, ccC=0, INT -> PC=001, int_ack_o one pulse, intz_o=1, intc_o=0; RETI -> PC=051, in_isr_o=0.
- rst_ni low mid-FETCH -> cyc/stb 0 same cycle, PC=000 after release; pc_upd_c during FETCH -> PC unchanged.
